// File: rtl/bouncing_shape_pkg.sv
// Shared types, palette and geometry helpers for the bouncing shape generator.
package bouncing_shape_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ModeStripes = 2'd0,
        ModeSquare  = 2'd1,
        ModeCircle  = 2'd2,
        ModeBlack   = 2'd3
    } mode_t;

    // {red, green, blue} masks, each bit fans out to a full channel
    localparam logic [2:0] RgbBlack   = 3'b000;
    localparam logic [2:0] RgbWhite   = 3'b111;
    localparam logic [2:0] RgbBlue    = 3'b001;
    localparam logic [2:0] RgbRed     = 3'b100;
    localparam logic [2:0] RgbGreen   = 3'b010;
    localparam logic [2:0] RgbMagenta = 3'b101;

    localparam int unsigned ScreenWidthDef  = 640;
    localparam int unsigned ScreenHeightDef = 480;
    localparam int unsigned ShapeSizeDef    = 64;

    // Largest top-left coordinate that keeps the shape fully on screen
    function automatic int unsigned max_pos(input int unsigned extent, input int unsigned size);
        return extent - size;
    endfunction

    function automatic logic [2:0] band_rgb(input int unsigned k);
        case (k % 3)
            0:       return RgbWhite;
            1:       return RgbBlue;
            default: return RgbRed;
        endcase
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Frame-tick detection, run/pause FSM, bouncing position/direction and bounce counter.
// STRIPE_SCROLL_EN adds a per-frame stripe scroll offset.
module sprite_motion
    import bouncing_shape_pkg::*;
#(
    parameter int unsigned screen_width  = ScreenWidthDef,
    parameter int unsigned screen_height = ScreenHeightDef,
    parameter int unsigned shape_size    = ShapeSizeDef,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [w_x-1:0] x,
    input  logic [w_y-1:0] y,
    input  logic [2:0]     speed,
    input  logic           go,
    input  logic           stop,
    output logic [w_x-1:0] pos_x,
    output logic [w_y-1:0] pos_y,
    output logic [1:0]     state,
    output logic [7:0]     bounce_cnt
`ifdef STRIPE_SCROLL_EN
    ,
    output logic [w_y-1:0] scroll_off
`endif
);

    localparam int unsigned XW = w_x + 1;
    localparam int unsigned YW = w_y + 1;
    localparam logic [w_x:0]   XMaxV = XW'(max_pos(screen_width, shape_size));
    localparam logic [w_y:0]   YMaxV = YW'(max_pos(screen_height, shape_size));
    localparam logic [w_x-1:0] XCtr  = w_x'(max_pos(screen_width, shape_size) / 2);
    localparam logic [w_y-1:0] YCtr  = w_y'(max_pos(screen_height, shape_size) / 2);

    state_t         state_q, state_d;
    logic [w_x-1:0] pos_x_q, pos_x_d;
    logic [w_y-1:0] pos_y_q, pos_y_d;
    logic           dir_x_q, dir_x_d;
    logic           dir_y_q, dir_y_d;
    logic [7:0]     bounce_q, bounce_d;
    logic           at0_q, at0_d;
    logic           tick, moving, recentre, hit_x, hit_y;
    logic [w_x:0]   sum_x;
    logic [w_y:0]   sum_y;

    assign at0_d  = (x == '0) && (y == '0);
    assign tick   = at0_d && !at0_q;
    assign moving = tick && (state_q == StRun);

    always_comb begin
        state_d  = state_q;
        recentre = 1'b0;
        unique case (state_q)
            StIdle:  if (go && !stop) state_d = StRun;
            StRun:   if (stop) state_d = StPause;
            StPause: begin
                if (stop) begin
                    state_d  = StIdle;
                    recentre = 1'b1;
                end else if (go) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // dir = 1 means moving towards larger coordinates
    always_comb begin
        pos_x_d = pos_x_q;
        dir_x_d = dir_x_q;
        hit_x   = 1'b0;
        sum_x   = {1'b0, pos_x_q} + XW'(speed);
        if (recentre) begin
            pos_x_d = XCtr;
            dir_x_d = 1'b1;
        end else if (moving) begin
            if (dir_x_q) begin
                if (sum_x > XMaxV) begin
                    pos_x_d = XMaxV[w_x-1:0];
                    dir_x_d = 1'b0;
                    hit_x   = 1'b1;
                end else begin
                    pos_x_d = sum_x[w_x-1:0];
                end
            end else if ({1'b0, pos_x_q} < XW'(speed)) begin
                pos_x_d = '0;
                dir_x_d = 1'b1;
                hit_x   = 1'b1;
            end else begin
                pos_x_d = pos_x_q - w_x'(speed);
            end
        end
    end

    always_comb begin
        pos_y_d = pos_y_q;
        dir_y_d = dir_y_q;
        hit_y   = 1'b0;
        sum_y   = {1'b0, pos_y_q} + YW'(speed);
        if (recentre) begin
            pos_y_d = YCtr;
            dir_y_d = 1'b1;
        end else if (moving) begin
            if (dir_y_q) begin
                if (sum_y > YMaxV) begin
                    pos_y_d = YMaxV[w_y-1:0];
                    dir_y_d = 1'b0;
                    hit_y   = 1'b1;
                end else begin
                    pos_y_d = sum_y[w_y-1:0];
                end
            end else if ({1'b0, pos_y_q} < YW'(speed)) begin
                pos_y_d = '0;
                dir_y_d = 1'b1;
                hit_y   = 1'b1;
            end else begin
                pos_y_d = pos_y_q - w_y'(speed);
            end
        end
    end

    assign bounce_d = bounce_q + 8'(hit_x) + 8'(hit_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pos_x_q  <= XCtr;
            pos_y_q  <= YCtr;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            bounce_q <= '0;
            at0_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            bounce_q <= bounce_d;
            at0_q    <= at0_d;
        end
    end

`ifdef STRIPE_SCROLL_EN
    logic [w_y-1:0] off_q, off_d;

    always_comb begin
        off_d = off_q;
        if (recentre) begin
            off_d = '0;
        end else if (moving) begin
            off_d = (off_q == w_y'(screen_height - 1)) ? '0 : off_q + w_y'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) off_q <= '0;
        else        off_q <= off_d;
    end

    assign scroll_off = off_q;
`endif

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign state      = state_q;
    assign bounce_cnt = bounce_q;

endmodule

// File: rtl/bouncing_shape_gen.sv
// Per-pixel colour generator: stripes, bouncing square or bouncing circle, 1-clk registered.
// Define STRIPE_SCROLL_EN to make stripes scroll one line per running frame.
module bouncing_shape_gen
    import bouncing_shape_pkg::*;
#(
    parameter int unsigned screen_width  = ScreenWidthDef,
    parameter int unsigned screen_height = ScreenHeightDef,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned w_red         = 4,
    parameter int unsigned w_green       = 4,
    parameter int unsigned w_blue        = 4,
    parameter int unsigned n_stripes     = 3,
    parameter int unsigned shape_size    = ShapeSizeDef
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [w_x-1:0]     x,
    input  logic [w_y-1:0]     y,
    input  logic [1:0]         mode,
    input  logic [2:0]         speed,
    input  logic               go,
    input  logic               stop,
    output logic [w_red-1:0]   red,
    output logic [w_green-1:0] green,
    output logic [w_blue-1:0]  blue,
    output logic [1:0]         state,
    output logic [7:0]         bounce_cnt
);

    localparam int unsigned XW     = w_x + 1;
    localparam int unsigned YW     = w_y + 1;
    localparam int unsigned SW     = 2 * XW + 1;
    localparam int unsigned Half   = shape_size / 2;
    localparam int unsigned BandH  = screen_height / n_stripes;
    localparam logic [SW-1:0] R2   = SW'(Half * Half);

    logic [w_x-1:0] pos_x;
    logic [w_y-1:0] pos_y;

    sprite_motion #(
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .shape_size    (shape_size),
        .w_x           (w_x),
        .w_y           (w_y)
    ) u_motion (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .speed      (speed),
        .go         (go),
        .stop       (stop),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .state      (state),
        .bounce_cnt (bounce_cnt)
`ifdef STRIPE_SCROLL_EN
        ,
        .scroll_off (scroll_off)
`endif
    );

`ifdef STRIPE_SCROLL_EN
    logic [w_y-1:0] scroll_off;
`endif

    logic [w_y:0]             yy;
    logic [2:0]               stripe_rgb;
    logic                     in_sq, in_circ;
    logic [w_x:0]             cx;
    logic [w_y:0]             cy;
    logic signed [w_x:0]      dx;
    logic signed [w_y:0]      dy;
    logic signed [2*XW-1:0]   dx_e, dx2;
    logic signed [2*YW-1:0]   dy_e, dy2;
    logic [SW-1:0]            dist2;
    logic [2:0]               rgb;
    logic [w_red-1:0]         red_q, red_d;
    logic [w_green-1:0]       green_q, green_d;
    logic [w_blue-1:0]        blue_q, blue_d;

    // Band select by comparator chain; rows past the last full band stay in the last band
    always_comb begin
`ifdef STRIPE_SCROLL_EN
        yy = {1'b0, y} + {1'b0, scroll_off};
        if (yy >= YW'(screen_height)) yy = yy - YW'(screen_height);
`else
        yy = {1'b0, y};
`endif
        stripe_rgb = band_rgb(0);
        for (int unsigned k = 1; k < n_stripes; k++) begin
            if (yy >= YW'(k * BandH)) stripe_rgb = band_rgb(k);
        end
    end

    always_comb begin
        in_sq = ({1'b0, x} >= {1'b0, pos_x}) && ({1'b0, x} < {1'b0, pos_x} + XW'(shape_size))
             && ({1'b0, y} >= {1'b0, pos_y}) && ({1'b0, y} < {1'b0, pos_y} + YW'(shape_size));
    end

    always_comb begin
        cx      = {1'b0, pos_x} + XW'(Half);
        cy      = {1'b0, pos_y} + YW'(Half);
        dx      = $signed({1'b0, x}) - $signed(cx);
        dy      = $signed({1'b0, y}) - $signed(cy);
        dx_e    = (2 * XW)'(dx);
        dy_e    = (2 * YW)'(dy);
        dx2     = dx_e * dx_e;
        dy2     = dy_e * dy_e;
        dist2   = SW'($unsigned(dx2)) + SW'($unsigned(dy2));
        in_circ = dist2 < R2;
    end

    always_comb begin
        rgb = RgbBlack;
        case (mode_t'(mode))
            ModeStripes: rgb = stripe_rgb;
            ModeSquare:  if (in_sq) rgb = RgbGreen;
            ModeCircle:  if (in_circ) rgb = RgbMagenta;
            default:     rgb = RgbBlack;
        endcase
        red_d   = {w_red{rgb[2]}};
        green_d = {w_green{rgb[1]}};
        blue_d  = {w_blue{rgb[0]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: doc/bouncing_shape_gen.md
Name: bouncing_shape_gen

Overview:
Per-pixel colour generator for the VGA/LCD graphics path. It draws either N horizontal colour bands, a moving square or a moving circle. The square and circle bounce off the screen edges, and motion updates once per frame. It sits between the display timing block (which supplies x, y) and the board's colour pins. Key pulses drive it through a small run/pause FSM.

Parameters:
screen_width, 640, visible pixels per line
screen_height, 480, visible lines
w_x, $clog2(screen_width), x coordinate width
w_y, $clog2(screen_height), y coordinate width
w_red / w_green / w_blue, 4, colour channel widths
n_stripes, 3, band count in stripe mode (1..8)
shape_size, 64, square side and circle diameter (even, < screen_height)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
x  in  w_x  current pixel column
y  in  w_y  current pixel row
mode  in  2  0 = stripes, 1 = square, 2 = circle, 3 = black
speed  in  3  pixels moved per frame per axis (0 = frozen)
go  in  1  one-cycle pulse: start or resume
stop  in  1  one-cycle pulse: pause, or recentre when already paused
red  out  w_red  pixel colour
green  out  w_green  pixel colour
blue  out  w_blue  pixel colour
state  out  2  FSM state (drives LEDs)
bounce_cnt  out  8  edge hits, wraps at 255

Behaviour:
- Reset, asynchronous: colour outputs = 0; state = IDLE; pos = (xmax/2, ymax/2); dir = (+,+); bounce_cnt = 0.
  - xmax = screen_width - shape_size; ymax = screen_height - shape_size.
- Colour latency: exactly 1 clk. Colour for (x, y) sampled at edge k appears after edge k, all channels registered.
- Frame tick: one-cycle pulse when (x==0 && y==0) is true and was false on the previous clk. A registered previous-value flag is used, so a pixel held at (0,0) gives one tick only.
- FSM states: IDLE=0, RUN=1, PAUSE=2. Transitions take effect on the next edge.
  - IDLE + go -> RUN.
  - RUN + stop -> PAUSE.
  - PAUSE + go -> RUN.
  - PAUSE + stop -> IDLE; pos is recentred and dir reset to (+,+).
  - go and stop asserted in the same cycle: stop wins.
  - go in RUN and stop in IDLE are ignored.
- Motion: only on a frame tick while in RUN. Each axis updates independently, with s = speed sampled at the tick:
  - dir + and pos + s > max: pos = max, dir flips, bounce_cnt += 1.
  - dir - and pos < s: pos = 0, dir flips, bounce_cnt += 1.
  - otherwise pos moves by s in dir.
  - A corner hit adds 2 to bounce_cnt. Arithmetic is done at w_x+1 / w_y+1 bits, so there is no wrap.
- Stripe mode: band height h = screen_height / n_stripes; band k = y / h, computed by comparator chain (no divider), clamped to n_stripes-1.
  - Palette by k mod 3: white (all '1), blue (blue='1), red (red='1).
- Square mode: green = '1 when pos_x <= x < pos_x + shape_size and pos_y <= y < pos_y + shape_size; else black.
- Circle mode: centre c = pos + shape_size/2, r = shape_size/2. Lit (red = '1, blue = '1) when (x-cx)² + (y-cy)² < r², strict.
  - Differences are signed w_x+1 / w_y+1 bits; the sum is 2*(w_x+1)+1 bits.
- Mode changes apply on the next pixel; motion state is unaffected.

Optional Feature:
STRIPE_SCROLL_EN.
- Defined: a w_y-bit scroll offset increments by 1 (mod screen_height) per frame tick in RUN. Stripe mode uses y' = (y + offset) mod screen_height. Offset is 0 at reset and when entering IDLE.
- Undefined: no offset register; stripes are static.

Decomposition:
- Package bouncing_shape_pkg holds:
  - state_t enum (IDLE/RUN/PAUSE)
  - mode_t enum
  - palette colour constants
  - the xmax/ymax localparam formulas
- Sub-module sprite_motion holds frame-tick detection, the FSM, pos/dir registers and bounce_cnt. It outputs pos_x, pos_y and state.
- The top level keeps the pixel shading and the output registers.

Test Plan:
- Reset, then release with mode=1: state=0, pos=(288,208), bounce_cnt=0. Pixel (288,208) gives green=F one clk later; (352,208) gives 0.
- go, speed=4, 3 frame ticks: state=1, pos=(300,220).
- Continue to 53 ticks at speed 4: y reaches 416 at tick 52. Tick 53 flips dir_y with pos_y=416 and bounce_cnt=1. x reaches 576 at tick 72 and bounces at tick 73 (bounce_cnt=2).
- Mode 0, n_stripes=3, static: y=0 gives (F,F,F); y=160 gives (0,0,F); y=479 gives (F,0,0), each 1 clk after x,y applied.
- Mode 2 with pos=(288,208): pixel (320,240) lit (F,0,F); (352,240) black.
- go and stop in the same cycle while in RUN gives PAUSE. A second stop gives IDLE with pos=(288,208). rst_n low mid-RUN clears outputs and state immediately, without a clock edge.
